// File: rtl/seg_multi_dri.sv
// seg_multi_dri: binary-to-BCD multi-digit seven-segment driver with blanking, overflow dashes and scanning.
// Optional SEG_MULTI_HEX_EN adds a hex_mode input that shows bin_in nibbles directly.
module seg_multi_dri #(
    parameter int NUM_DIG   = 6,
    parameter int BIN_W     = 20,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int SCAN_FREQ = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BIN_W-1:0]   bin_in,
    input  logic               bin_vld,
    input  logic [NUM_DIG-1:0] point,
    input  logic               en,
`ifdef SEG_MULTI_HEX_EN
    input  logic               hex_mode,
`endif
    output logic               busy,
    output logic [NUM_DIG-1:0] sel,
    output logic [7:0]         seg_led
);
    localparam int BW    = 4 * NUM_DIG;
    localparam int DWELL = (CLK_FREQ / SCAN_FREQ < 2) ? 2 : CLK_FREQ / SCAN_FREQ;
    localparam int DW    = $clog2(DWELL);
    localparam int IW    = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int CW    = $clog2(BIN_W + 1);
    localparam logic [63:0] DEC_MAX = 64'(10 ** NUM_DIG - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state;
    logic [BIN_W-1:0]   sh, pend_val, ld_val;
    logic [BW-1:0]      bcd, bcd_adj, disp_bcd, src_bcd;
    logic [CW-1:0]      cnt;
    logic               ovf, pend, pend_hex, disp_ovf, src_ovf;
    logic [NUM_DIG-1:0] disp_blank, blank_nxt, src_blank;
    logic [DW-1:0]      dcnt;
    logic [IW-1:0]      idx, idx_nxt;
    logic               hex_in, ld_hex, start, tc, zero_run;
    logic [63:0]        ld64;
    logic [7:0]         base, seg_nxt;

`ifdef SEG_MULTI_HEX_EN
    assign hex_in = hex_mode;
`else
    assign hex_in = 1'b0;
`endif

    function automatic logic [7:0] seg_dec(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // A strobe during DONE is taken directly as the next job, overriding any pending value
    assign start  = (state == IDLE && bin_vld) || (state == DONE && (bin_vld || pend));
    assign ld_val = bin_vld ? bin_in : pend_val;
    assign ld_hex = bin_vld ? hex_in : pend_hex;
    assign ld64   = 64'(ld_val);

    always_comb begin
        bcd_adj   = bcd;
        blank_nxt = '0;
        zero_run  = 1'b1;
        for (int i = 0; i < NUM_DIG; i++)
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        for (int i = NUM_DIG - 1; i > 0; i--) begin
            zero_run     = zero_run && (bcd[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_run;
        end
    end

    // Display data is taken from the conversion result during DONE so the new value shows one cycle earlier
    assign src_bcd   = (state == DONE) ? bcd : disp_bcd;
    assign src_blank = (state == DONE) ? blank_nxt : disp_blank;
    assign src_ovf   = (state == DONE) ? ovf : disp_ovf;
    assign tc        = dcnt == DW'(DWELL - 1);
    assign idx_nxt   = (en && tc) ? ((idx == IW'(NUM_DIG - 1)) ? '0 : idx + IW'(1)) : idx;
    assign base      = src_ovf ? 8'hBF : src_blank[idx_nxt] ? 8'hFF : seg_dec(src_bcd[4*idx_nxt +: 4]);
    assign seg_nxt   = {base[7] & ~point[idx_nxt], base[6:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            sh         <= '0;
            bcd        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            pend       <= 1'b0;
            pend_val   <= '0;
            pend_hex   <= 1'b0;
            disp_bcd   <= '0;
            disp_blank <= {{(NUM_DIG-1){1'b1}}, 1'b0};
            disp_ovf   <= 1'b0;
        end else begin
            if (state == DONE) begin
                disp_bcd   <= bcd;
                disp_blank <= blank_nxt;
                disp_ovf   <= ovf;
                pend       <= 1'b0;
            end else if (state != IDLE && bin_vld) begin
                pend     <= 1'b1;
                pend_val <= bin_in;
                pend_hex <= hex_in;
            end
            if (state == CONV) begin
                bcd <= {bcd_adj[BW-2:0], sh[BIN_W-1]};
                sh  <= sh << 1;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(BIN_W - 1))
                    state <= DONE;
            end else if (start) begin
                busy  <= 1'b1;
                state <= ld_hex ? DONE : CONV;
                cnt   <= '0;
                sh    <= ld_val;
                bcd   <= ld_hex ? ld64[BW-1:0] : '0;
                ovf   <= ld_hex ? ((ld64 >> BW) != 64'd0) : (ld64 > DEC_MAX);
            end else if (state == DONE) begin
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt    <= '0;
            idx     <= '0;
            sel     <= '1;
            seg_led <= 8'hFF;
        end else if (en) begin
            dcnt    <= tc ? '0 : dcnt + DW'(1);
            idx     <= idx_nxt;
            sel     <= ~(NUM_DIG'(1) << idx_nxt);
            seg_led <= seg_nxt;
        end else begin
            sel     <= '1;
            seg_led <= 8'hFF;
        end
    end
endmodule

// File: tb/tb_seg_multi_dri.sv
// tb_seg_multi_dri: directed-vector bench for seg_multi_dri (decimal build, 10-cycle dwell).
module tb_seg_multi_dri;
    logic        clk = 1'b0, rst_n = 1'b0, bin_vld = 1'b0, en = 1'b1, busy;
    logic [19:0] bin_in = '0;
    logic [5:0]  point = '0, sel;
    logic [7:0]  seg_led;
    int          checks = 0, failures = 0;

    typedef struct packed {
        logic [19:0]     v;
        logic [5:0]      p;
        logic [5:0][7:0] e;
    } vec_t;
    vec_t tbl[9];

    seg_multi_dri #(.NUM_DIG(6), .BIN_W(20), .CLK_FREQ(1000), .SCAN_FREQ(100)) dut (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bin_vld(bin_vld), .point(point),
        .en(en), .busy(busy), .sel(sel), .seg_led(seg_led)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic int sel_idx(input logic [5:0] s);
        logic [5:0] m;
        for (int k = 0; k < 6; k++) begin
            m = 6'b1 << k;
            if (s == ~m) return k;
        end
        return -1;
    endfunction

    // One full scan period observes every digit once
    task automatic capture(input logic [5:0][7:0] e, input string nm);
        logic [7:0] got[6];
        bit seen[6];
        int k;
        for (int d = 0; d < 6; d++) begin seen[d] = 0; got[d] = '0; end
        repeat (60) begin
            @(negedge clk);
            k = sel_idx(sel);
            if (k >= 0) begin got[k] = seg_led; seen[k] = 1; end
        end
        for (int d = 0; d < 6; d++)
            check($sformatf("%s_d%0d", nm, d), seen[d] ? {56'b0, got[d]} : 64'hFFFF, {56'b0, e[d]});
    endtask

    task automatic pulse(input logic [19:0] v);
        @(negedge clk);
        bin_in  = v;
        bin_vld = 1'b1;
        @(negedge clk);
        bin_vld = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 200) begin n++; @(negedge clk); end
    endtask

    task automatic wait_change(output int n, output int ni);
        logic [5:0] prev;
        prev = sel;
        n = 0;
        do begin @(negedge clk); n++; end while (sel == prev && n < 100);
        ni = sel_idx(sel);
    endtask

    initial begin
        int n, ni, old, len, bad;
        logic [5:0] s0;
        logic [7:0] e42;
        tbl[0] = '{20'd123456,  6'b000000, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}};
        tbl[1] = '{20'd1000000, 6'b000000, {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF}};
        tbl[2] = '{20'd999999,  6'b000000, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
        tbl[3] = '{20'd7,       6'b000010, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hF8}};
        tbl[4] = '{20'd1000000, 6'b000001, {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'h3F}};
        tbl[5] = '{20'd100500,  6'b000000, {8'hF9, 8'hC0, 8'hC0, 8'h92, 8'hC0, 8'hC0}};
        tbl[6] = '{20'd1048575, 6'b100000, {8'h3F, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF}};
        tbl[7] = '{20'd0,       6'b000001, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40}};
        tbl[8] = '{20'd10,      6'b000000, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hC0}};

        repeat (3) @(negedge clk);
        check("rst_sel", sel, 6'h3F);
        check("rst_seg", seg_led, 8'hFF);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        capture({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}, "post_rst");

        wait_change(n, ni);
        for (int r = 0; r < 7; r++) begin
            old = ni;
            wait_change(n, ni);
            check("dwell_len", n, 10);
            check("dwell_idx", ni, (old + 1) % 6);
        end

        for (int t = 0; t < 9; t++) begin
            point = tbl[t].p;
            pulse(tbl[t].v);
            busy_len(n);
            check($sformatf("busy_len_v%0d", t), n, 21);
            capture(tbl[t].e, $sformatf("vec%0d", t));
        end

        // 42 converting; 305 then 88 arrive while busy, so only 88 follows back-to-back
        point = '0;
        @(negedge clk);
        bin_in  = 20'd42;
        bin_vld = 1'b1;
        len = -1;
        bad = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (!busy && len < 0) len = k - 1;
            if (sel_idx(sel) == 2 && seg_led != 8'hFF) bad = 1;
            if (k == 22) begin
                e42 = (sel_idx(sel) == 0) ? 8'hA4 : (sel_idx(sel) == 1) ? 8'h99 : 8'hFF;
                check("b2b_42_shown", seg_led, e42);
            end
            bin_vld = (k == 4 || k == 8);
            bin_in  = (k == 4) ? 20'd305 : (k == 8) ? 20'd88 : bin_in;
        end
        check("b2b_busy_len", len, 42);
        capture({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h80}, "b2b_88");
        check("b2b_305_hidden", bad, 0);

        wait_change(n, ni);
        s0 = sel;
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en0_sel", sel, 6'h3F);
        check("en0_seg", seg_led, 8'hFF);
        repeat (24) @(negedge clk);
        check("en0_sel_hold", sel, 6'h3F);
        check("en0_seg_hold", seg_led, 8'hFF);
        en = 1'b1;
        @(negedge clk);
        check("en1_idx_kept", sel, s0);
        wait_change(n, ni);
        check("en1_dwell_rest", n, 6);

        pulse(20'd123456);
        repeat (5) @(negedge clk);
        pulse(20'd777);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_sel", sel, 6'h3F);
        check("mid_rst_seg", seg_led, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (30) begin @(negedge clk); if (busy) n++; end
        check("mid_rst_no_pend", n, 0);
        capture({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}, "mid_rst_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
